reg_write_queue: RTL

Write-side companion to the MIPS register file: collects register-write requests from the in-order pipeline writeback and from the multi-cycle multiply/divide unit, and orders them in a small circular queue. It drains exactly one write per cycle into the register file's single write port (`RegWrite`/`WAddr`/`WData`). It also offers a forwarding lookup so readers can see values that are still queued and not yet committed.

---
 rtl/reg_write_pkg.sv | 19 +
 rtl/reg_write_fifo.sv | 76 +++++++
 rtl/reg_write_queue.sv | 64 ++++++
 3 files changed

// File: rtl/reg_write_pkg.sv
// Shared types and helpers for the register-write queue: the entry layout and
// the set of registers whose writes are silently dropped.
package reg_write_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_K0   = 5'd26;
    localparam logic [4:0] REG_K1   = 5'd27;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wq_entry_t;

    // $zero is hard-wired and $k0/$k1 belong to the kernel, so writes to them never reach the file
    function automatic logic is_protected(input logic [4:0] addr);
        return (addr == REG_ZERO) || (addr == REG_K0) || (addr == REG_K1);
    endfunction

endpackage

// File: rtl/reg_write_fifo.sv
// Circular buffer with two enqueue ports (port 0 is the older entry), one
// dequeue port and a youngest-match search over the occupied entries.
module reg_write_fifo
    import reg_write_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enq0_i,
    input  wq_entry_t                    enq0_entry_i,
    input  logic                         enq1_i,
    input  wq_entry_t                    enq1_entry_i,
    input  logic                         deq_i,
    output wq_entry_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [4:0]                   lookup_addr_i,
    output logic                         lookup_hit_o,
    output logic [31:0]                  lookup_data_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    wq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW-1:0]     tail1;
    logic [CW-1:0]     count_q, count_d;

    // The second producer lands just behind the first one when both push together
    always_comb begin
        tail1   = tail_q + PW'(enq0_i);
        tail_d  = tail_q + PW'(enq0_i) + PW'(enq1_i);
        head_d  = head_q + PW'(deq_i);
        count_d = count_q + CW'(enq0_i) + CW'(enq1_i) - CW'(deq_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (enq0_i) mem_q[tail_q] <= enq0_entry_i;
            if (enq1_i) mem_q[tail1]  <= enq1_entry_i;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one
    always_comb begin
        logic [PW-1:0] idx;
        idx           = '0;
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[idx].addr == lookup_addr_i)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = mem_q[idx].data;
            end
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/reg_write_queue.sv
// Merges pipeline and mult/div register writes into one ordered stream that
// drives the register file's single write port, with forwarding of queued data.
module reg_write_queue
    import reg_write_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         PipeValid,
    input  logic [4:0]                   PipeAddr,
    input  logic [31:0]                  PipeData,
    output logic                         PipeReady,
    input  logic                         MdValid,
    input  logic [4:0]                   MdAddr,
    input  logic [31:0]                  MdData,
    output logic                         MdReady,
    output logic                         RegWrite,
    output logic [4:0]                   WAddr,
    output logic [31:0]                  WData,
    input  logic [4:0]                   LookupReg,
    output logic                         LookupHit,
    output logic [31:0]                  LookupData,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic        pipeEnq;
    logic        mdEnq;
    wq_entry_t   headEntry;
    logic        fifoHit;
    logic [31:0] fifoData;

    // Readiness looks at the pre-drain occupancy; the pop only helps next cycle
    assign PipeReady = ({1'b0, Count} < DEPTH_W);
    assign pipeEnq   = PipeValid & PipeReady & ~is_protected(PipeAddr);
    assign MdReady   = (({1'b0, Count} + (CW + 1)'(pipeEnq)) < DEPTH_W);
    assign mdEnq     = MdValid & MdReady & ~is_protected(MdAddr);

    reg_write_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i         (Clk),
        .reset_i       (Reset),
        .enq0_i        (pipeEnq),
        .enq0_entry_i  ('{addr: PipeAddr, data: PipeData}),
        .enq1_i        (mdEnq),
        .enq1_entry_i  ('{addr: MdAddr, data: MdData}),
        .deq_i         (RegWrite),
        .head_o        (headEntry),
        .count_o       (Count),
        .lookup_addr_i (LookupReg),
        .lookup_hit_o  (fifoHit),
        .lookup_data_o (fifoData)
    );

    // A reset cycle discards the queue, so the head must not be written on that edge
    assign RegWrite   = (Count != '0) & ~Reset;
    assign WAddr      = RegWrite ? headEntry.addr : 5'd0;
    assign WData      = RegWrite ? headEntry.data : 32'd0;
    assign LookupHit  = fifoHit & ~is_protected(LookupReg);
    assign LookupData = LookupHit ? fifoData : 32'd0;

endmodule
